// File: rtl/pipeline_stall_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller_pkg
// Description : Shared definitions for the pipeline stall controller: FSM
//               state encodings, bit positions of the hold/reset control
//               vector and the canned control patterns built from them.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN         = 2'b00,
    ST_DMEM_WAIT   = 2'b01,
    ST_MULDIV_WAIT = 2'b10
  } state_e;

  // Bit positions inside the pipeline control vector
  localparam int IDX_PC_HOLD       = 0;
  localparam int IDX_IF_ID_RESET   = 1;
  localparam int IDX_IF_ID_HOLD    = 2;
  localparam int IDX_ID_EX_RESET   = 3;
  localparam int IDX_ID_EX_HOLD    = 4;
  localparam int IDX_EX_MEM_RESET  = 5;
  localparam int IDX_EX_MEM_HOLD   = 6;
  localparam int IDX_MEM_WB_RESET  = 7;
  localparam int CTL_W             = 8;

  typedef logic [CTL_W-1:0] ctl_t;

  function automatic ctl_t ctl_bit(input int idx);
    ctl_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Data-memory wait: freeze everything up to EX/MEM, bubble into MEM/WB
  localparam ctl_t C_VEC_DMEM   = ctl_bit(IDX_PC_HOLD)    | ctl_bit(IDX_IF_ID_HOLD) |
                                  ctl_bit(IDX_ID_EX_HOLD) | ctl_bit(IDX_EX_MEM_HOLD) |
                                  ctl_bit(IDX_MEM_WB_RESET);
  // Mul/div in flight: freeze front end, bubble into EX/MEM
  localparam ctl_t C_VEC_MULDIV = ctl_bit(IDX_PC_HOLD)    | ctl_bit(IDX_IF_ID_HOLD) |
                                  ctl_bit(IDX_ID_EX_HOLD) | ctl_bit(IDX_EX_MEM_RESET);
  // Taken branch/jump: squash the two younger instructions, PC redirects
  localparam ctl_t C_VEC_BJ     = ctl_bit(IDX_IF_ID_RESET) | ctl_bit(IDX_ID_EX_RESET);
  // Load-use: hold fetch/decode one cycle, bubble into EX
  localparam ctl_t C_VEC_LU     = ctl_bit(IDX_PC_HOLD) | ctl_bit(IDX_IF_ID_HOLD) |
                                  ctl_bit(IDX_ID_EX_RESET);
  // Fetch not complete: hold PC, bubble into decode
  localparam ctl_t C_VEC_IMEM   = ctl_bit(IDX_PC_HOLD) | ctl_bit(IDX_IF_ID_RESET);

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_controller_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : stall_watchdog
// Description : Counts consecutive stalled cycles; raises a sticky flag once
//               the count reaches STALL_LIMIT. Flag clears only on reset.
// Ports       : i_clk      - clock, rising edge
//               i_rst      - asynchronous active-high reset
//               i_stalled  - controller is outside RUN this cycle
//               o_timeout  - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module stall_watchdog #(
  parameter int STALL_LIMIT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stalled,
  output logic o_timeout
);

  localparam int               CW      = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0]    C_LIMIT = CW'(STALL_LIMIT);

  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!i_stalled) begin
        r_cnt <= '0;
      end else if (r_cnt != C_LIMIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Flag sets on the edge that brings the count to the limit
      if (i_stalled && (r_cnt == C_LIMIT - 1'b1)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller
// Description : Cycle-level sequencer for the 5-stage pipeline. Arbitrates
//               DMEM wait > mul/div > branch flush > load-use > IMEM wait,
//               produces PC / pipeline-register hold and bubble controls,
//               starts the iterative mul/div unit, counts PC_HOLD cycles and
//               watches for runaway stalls.
// Ports       : CLK, RESET        - clock / async active-high reset
//               BJ_SIG            - branch/jump taken in EX
//               LU_HAZ_SIG        - load-use hazard in ID
//               IMEM_BUSY         - fetch incomplete
//               DMEM_BUSY         - data access incomplete
//               MULDIV_REQ/DONE   - mul/div request level / done pulse
//               MULDIV_START      - start pulse to the mul/div unit
//               PC_HOLD, PR_*     - pipeline hold / bubble controls
//               STALL_TIMEOUT     - sticky watchdog flag
//               STALL_CYCLES      - saturating PC_HOLD cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int STALL_LIMIT     = 1024,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       BJ_SIG,
  input  logic                       LU_HAZ_SIG,
  input  logic                       IMEM_BUSY,
  input  logic                       DMEM_BUSY,
  input  logic                       MULDIV_REQ,
  input  logic                       MULDIV_DONE,
  output logic                       MULDIV_START,
  output logic                       PC_HOLD,
  output logic                       PR_IF_ID_RESET,
  output logic                       PR_IF_ID_HOLD,
  output logic                       PR_ID_EX_RESET,
  output logic                       PR_ID_EX_HOLD,
  output logic                       PR_EX_MEM_RESET,
  output logic                       PR_EX_MEM_HOLD,
  output logic                       PR_MEM_WB_RESET,
  output logic                       STALL_TIMEOUT,
  output logic [STALL_CNT_WIDTH-1:0] STALL_CYCLES
);

  state_e                     r_state;
  state_e                     w_next;
  logic                       r_done_latch;
  logic                       w_md_complete;
  ctl_t                       w_ctl;
  logic                       w_start;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cycles;

  // Mul/div finishes once its result can actually move into EX/MEM, i.e.
  // a done pulse (now or remembered from a DMEM wait) with memory free.
  assign w_md_complete = (r_state == ST_MULDIV_WAIT) && !DMEM_BUSY &&
                         (MULDIV_DONE || r_done_latch);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN, ST_DMEM_WAIT: begin
        if (DMEM_BUSY) begin
          w_next = ST_DMEM_WAIT;
        end else if (MULDIV_REQ) begin
          w_next = ST_MULDIV_WAIT;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_MULDIV_WAIT: begin
        if (w_md_complete) begin
          w_next = ST_RUN;
        end
      end
      default: w_next = ST_RUN;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    w_ctl   = '0;
    w_start = 1'b0;
    if (RESET) begin
      w_ctl   = '0;
    end else if (DMEM_BUSY) begin
      w_ctl   = C_VEC_DMEM;
    end else if (r_state == ST_MULDIV_WAIT) begin
      // Completion cycle leaves everything released so EX/MEM captures the result
      if (!w_md_complete) begin
        w_ctl = C_VEC_MULDIV;
      end
    end else if (MULDIV_REQ) begin
      w_ctl   = C_VEC_MULDIV;
      w_start = 1'b1;
    end else if (BJ_SIG) begin
      w_ctl   = C_VEC_BJ;
    end else if (LU_HAZ_SIG) begin
      w_ctl   = C_VEC_LU;
    end else if (IMEM_BUSY) begin
      w_ctl   = C_VEC_IMEM;
    end
  end

  // Remembers a done pulse that arrived while a memory wait blocked EX/MEM
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_done_latch <= 1'b0;
    end else if (w_md_complete) begin
      r_done_latch <= 1'b0;
    end else if ((r_state == ST_MULDIV_WAIT) && MULDIV_DONE && DMEM_BUSY) begin
      r_done_latch <= 1'b1;
    end
  end

  // Saturating PC_HOLD cycle counter
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_stall_cycles <= '0;
    end else if (w_ctl[IDX_PC_HOLD] && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  stall_watchdog #(
    .STALL_LIMIT (STALL_LIMIT)
  ) u_watchdog (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_stalled (r_state != ST_RUN),
    .o_timeout (STALL_TIMEOUT)
  );

  assign MULDIV_START    = w_start;
  assign PC_HOLD         = w_ctl[IDX_PC_HOLD];
  assign PR_IF_ID_RESET  = w_ctl[IDX_IF_ID_RESET];
  assign PR_IF_ID_HOLD   = w_ctl[IDX_IF_ID_HOLD];
  assign PR_ID_EX_RESET  = w_ctl[IDX_ID_EX_RESET];
  assign PR_ID_EX_HOLD   = w_ctl[IDX_ID_EX_HOLD];
  assign PR_EX_MEM_RESET = w_ctl[IDX_EX_MEM_RESET];
  assign PR_EX_MEM_HOLD  = w_ctl[IDX_EX_MEM_HOLD];
  assign PR_MEM_WB_RESET = w_ctl[IDX_MEM_WB_RESET];
  assign STALL_CYCLES    = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_controller
// Description : Directed-vector scoreboard bench for pipeline_stall_controller
//               (STALL_LIMIT=8, STALL_CNT_WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

  // Input bit patterns {BJ, LU, IMEM, DMEM, REQ, DONE}
  localparam logic [5:0] I_NO = 6'b000000;
  localparam logic [5:0] I_BJ = 6'b100000;
  localparam logic [5:0] I_LU = 6'b010000;
  localparam logic [5:0] I_IM = 6'b001000;
  localparam logic [5:0] I_DM = 6'b000100;
  localparam logic [5:0] I_RQ = 6'b000010;
  localparam logic [5:0] I_DN = 6'b000001;

  // Expected control vectors {MEM_WB_R, EX_MEM_H, EX_MEM_R, ID_EX_H, ID_EX_R, IF_ID_H, IF_ID_R, PC_H}
  localparam logic [7:0] E_IDLE = 8'h00;
  localparam logic [7:0] E_BJ   = 8'h0A;
  localparam logic [7:0] E_LU   = 8'h0D;
  localparam logic [7:0] E_IMEM = 8'h03;
  localparam logic [7:0] E_MD   = 8'h35;
  localparam logic [7:0] E_DM   = 8'hD5;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       BJ_SIG, LU_HAZ_SIG, IMEM_BUSY, DMEM_BUSY, MULDIV_REQ, MULDIV_DONE;
  logic       MULDIV_START, PC_HOLD;
  logic       PR_IF_ID_RESET, PR_IF_ID_HOLD, PR_ID_EX_RESET, PR_ID_EX_HOLD;
  logic       PR_EX_MEM_RESET, PR_EX_MEM_HOLD, PR_MEM_WB_RESET;
  logic       STALL_TIMEOUT;
  logic [3:0] STALL_CYCLES;
  logic [7:0] act_ctl;

  typedef struct packed {
    logic [15:0] id;
    logic [7:0]  ctl;
    logic        st;
    logic [3:0]  cnt;
    logic        to;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_vec    = 0;

  always #5 CLK = ~CLK;

  pipeline_stall_controller #(
    .STALL_LIMIT     (8),
    .STALL_CNT_WIDTH (4)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .BJ_SIG          (BJ_SIG),
    .LU_HAZ_SIG      (LU_HAZ_SIG),
    .IMEM_BUSY       (IMEM_BUSY),
    .DMEM_BUSY       (DMEM_BUSY),
    .MULDIV_REQ      (MULDIV_REQ),
    .MULDIV_DONE     (MULDIV_DONE),
    .MULDIV_START    (MULDIV_START),
    .PC_HOLD         (PC_HOLD),
    .PR_IF_ID_RESET  (PR_IF_ID_RESET),
    .PR_IF_ID_HOLD   (PR_IF_ID_HOLD),
    .PR_ID_EX_RESET  (PR_ID_EX_RESET),
    .PR_ID_EX_HOLD   (PR_ID_EX_HOLD),
    .PR_EX_MEM_RESET (PR_EX_MEM_RESET),
    .PR_EX_MEM_HOLD  (PR_EX_MEM_HOLD),
    .PR_MEM_WB_RESET (PR_MEM_WB_RESET),
    .STALL_TIMEOUT   (STALL_TIMEOUT),
    .STALL_CYCLES    (STALL_CYCLES)
  );

  assign act_ctl = {PR_MEM_WB_RESET, PR_EX_MEM_HOLD, PR_EX_MEM_RESET, PR_ID_EX_HOLD,
                    PR_ID_EX_RESET, PR_IF_ID_HOLD, PR_IF_ID_RESET, PC_HOLD};

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec%0d: got %0h expected %0h", nm, id, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] in);
    {BJ_SIG, LU_HAZ_SIG, IMEM_BUSY, DMEM_BUSY, MULDIV_REQ, MULDIV_DONE} = in;
  endtask

  // One clock cycle of stimulus; its expected response goes to the scoreboard
  task automatic step(input logic [5:0] in, input logic [7:0] ctl, input logic st,
                      input logic [3:0] cnt, input logic to);
    exp_t e;
    @(posedge CLK);
    #1;
    drive(in);
    n_vec++;
    e.id  = 16'(n_vec);
    e.ctl = ctl;
    e.st  = st;
    e.cnt = cnt;
    e.to  = to;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    drive(I_NO);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest expectation
  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("ctl",  int'(mon_e.id), 32'(act_ctl),       32'(mon_e.ctl));
      chk("start", int'(mon_e.id), 32'(MULDIV_START), 32'(mon_e.st));
      chk("cycles", int'(mon_e.id), 32'(STALL_CYCLES), 32'(mon_e.cnt));
      chk("timeout", int'(mon_e.id), 32'(STALL_TIMEOUT), 32'(mon_e.to));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Outputs forced low during reset even with active inputs
    RESET = 1'b1;
    drive(I_BJ | I_DM | I_RQ);
    #3;
    chk("rst_ctl",   0, 32'(act_ctl),       32'h0);
    chk("rst_start", 0, 32'(MULDIV_START),  32'h0);
    chk("rst_cycles",0, 32'(STALL_CYCLES),  32'h0);
    chk("rst_to",    0, 32'(STALL_TIMEOUT), 32'h0);
    drive(I_NO);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Single sources and priority among flush/hazard/fetch
    step(I_NO,         E_IDLE, 1'b0, 4'd0, 1'b0);
    step(I_NO,         E_IDLE, 1'b0, 4'd0, 1'b0);
    step(I_BJ | I_LU,  E_BJ,   1'b0, 4'd0, 1'b0);
    step(I_LU,         E_LU,   1'b0, 4'd0, 1'b0);
    step(I_IM,         E_IMEM, 1'b0, 4'd1, 1'b0);
    step(I_BJ | I_IM,  E_BJ,   1'b0, 4'd2, 1'b0);
    step(I_LU | I_IM,  E_LU,   1'b0, 4'd2, 1'b0);
    step(I_NO,         E_IDLE, 1'b0, 4'd3, 1'b0);
    do_reset();

    // Mul/div, done 5 cycles after start
    step(I_RQ,         E_MD,   1'b1, 4'd0, 1'b0);
    step(I_RQ,         E_MD,   1'b0, 4'd1, 1'b0);
    step(I_RQ,         E_MD,   1'b0, 4'd2, 1'b0);
    step(I_RQ,         E_MD,   1'b0, 4'd3, 1'b0);
    step(I_RQ,         E_MD,   1'b0, 4'd4, 1'b0);
    step(I_RQ | I_DN,  E_IDLE, 1'b0, 4'd5, 1'b0);
    step(I_NO,         E_IDLE, 1'b0, 4'd5, 1'b0);
    step(I_DN,         E_IDLE, 1'b0, 4'd5, 1'b0);
    do_reset();

    // Mul/div done arrives under a 3-cycle memory wait
    step(I_RQ | I_DN,         E_MD,   1'b1, 4'd0, 1'b0);
    step(I_RQ | I_DM,         E_DM,   1'b0, 4'd1, 1'b0);
    step(I_RQ | I_DM | I_DN,  E_DM,   1'b0, 4'd2, 1'b0);
    step(I_RQ | I_DM,         E_DM,   1'b0, 4'd3, 1'b0);
    step(I_RQ,                E_IDLE, 1'b0, 4'd4, 1'b0);
    step(I_LU,                E_LU,   1'b0, 4'd4, 1'b0);
    do_reset();

    // Memory wait from RUN, then mul/div starts out of DMEM_WAIT
    step(I_DM | I_RQ,  E_DM,   1'b0, 4'd0, 1'b0);
    step(I_RQ,         E_MD,   1'b1, 4'd1, 1'b0);
    step(I_RQ | I_DN,  E_IDLE, 1'b0, 4'd2, 1'b0);
    step(I_NO,         E_IDLE, 1'b0, 4'd2, 1'b0);
    do_reset();

    // Watchdog: DMEM busy 10 cycles, flag after 8 DMEM_WAIT cycles
    for (int k = 0; k < 10; k++) begin
      step(I_DM, E_DM, 1'b0, 4'(k), (k == 9) ? 1'b1 : 1'b0);
    end
    step(I_NO,         E_IDLE, 1'b0, 4'd10, 1'b1);
    step(I_NO,         E_IDLE, 1'b0, 4'd10, 1'b1);

    // Counter saturation at 4'hF
    for (int k = 0; k < 8; k++) begin
      step(I_LU, E_LU, 1'b0, (k < 5) ? 4'(10 + k) : 4'hF, 1'b1);
    end
    step(I_NO,         E_IDLE, 1'b0, 4'hF, 1'b1);

    // Asynchronous reset in the middle of MULDIV_WAIT
    step(I_RQ,         E_MD,   1'b1, 4'hF, 1'b1);
    step(I_RQ,         E_MD,   1'b0, 4'hF, 1'b1);
    @(negedge CLK);
    #2;
    drive(I_RQ | I_DM);
    RESET = 1'b1;
    #1;
    chk("arst_ctl",   0, 32'(act_ctl),       32'h0);
    chk("arst_start", 0, 32'(MULDIV_START),  32'h0);
    chk("arst_cycles",0, 32'(STALL_CYCLES),  32'h0);
    chk("arst_to",    0, 32'(STALL_TIMEOUT), 32'h0);
    drive(I_NO);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    // Back in RUN: the request is started afresh
    step(I_RQ,         E_MD,   1'b1, 4'd0, 1'b0);
    step(I_RQ | I_DN,  E_IDLE, 1'b0, 4'd1, 1'b0);
    step(I_NO,         E_IDLE, 1'b0, 4'd1, 1'b0);

    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Cycle-level sequencer for the 5-stage CPU pipeline. Generates all PC and pipeline-register hold/reset controls.
- Arbitrates between competing stall and flush sources: data-memory wait, iterative mul/div, branch/jump flush, load-use hazard and instruction-memory wait.
- Drives the start handshake of the iterative mul/div unit.
- Keeps a stall-cycle performance counter and a stall watchdog.

Parameters:
- STALL_LIMIT, 1024, consecutive non-RUN cycles before STALL_TIMEOUT sets.
- STALL_CNT_WIDTH, 32, width of STALL_CYCLES.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- BJ_SIG  in  1  branch/jump taken in EX.
- LU_HAZ_SIG  in  1  load-use hazard detected in ID.
- IMEM_BUSY  in  1  instruction fetch not complete this cycle.
- DMEM_BUSY  in  1  data access in MEM not complete this cycle.
- MULDIV_REQ  in  1  instruction in EX is mul/div (level).
- MULDIV_DONE  in  1  iterative unit result valid (1-cycle pulse).
- MULDIV_START  out  1  1-cycle start pulse to iterative unit.
- PC_HOLD  out  1  freeze PC.
- PR_IF_ID_RESET  out  1  bubble into IF/ID.
- PR_IF_ID_HOLD  out  1  freeze IF/ID.
- PR_ID_EX_RESET  out  1  bubble into ID/EX.
- PR_ID_EX_HOLD  out  1  freeze ID/EX.
- PR_EX_MEM_RESET  out  1  bubble into EX/MEM.
- PR_EX_MEM_HOLD  out  1  freeze EX/MEM.
- PR_MEM_WB_RESET  out  1  bubble into MEM/WB.
- STALL_TIMEOUT  out  1  sticky watchdog flag.
- STALL_CYCLES  out  STALL_CNT_WIDTH  saturating count of PC_HOLD cycles.

Behaviour:
- Reset:
  - RESET high: state=RUN, done_latch=0, watchdog count=0, STALL_TIMEOUT=0, STALL_CYCLES=0.
  - All control outputs and MULDIV_START are forced 0 while RESET=1, independent of inputs.
- Output timing: control outputs are Mealy, combinational from state and inputs, with zero-cycle latency.
- FSM states: RUN, DMEM_WAIT, MULDIV_WAIT.
- Priority, highest first: DMEM_BUSY > mul/div > BJ_SIG > LU_HAZ_SIG > IMEM_BUSY.
- DMEM_BUSY=1 (any state):
  - PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD = 1; MEM_WB_RESET=1; all other outputs 0.
  - From RUN, next state is DMEM_WAIT.
- DMEM_WAIT with DMEM_BUSY=0:
  - Outputs evaluated as in RUN this same cycle.
  - State returns to RUN, or moves to MULDIV_WAIT if the start condition holds.
- RUN, DMEM_BUSY=0, MULDIV_REQ=1:
  - MULDIV_START=1; PC_HOLD, IF_ID_HOLD, ID_EX_HOLD = 1; EX_MEM_RESET=1.
  - Next state is MULDIV_WAIT.
- MULDIV_WAIT:
  - MULDIV_START=0.
  - Until completion: same holds as the start cycle plus EX_MEM_RESET=1.
  - MULDIV_DONE=1 with DMEM_BUSY=0 is completion: all outputs 0 that cycle (result latches into EX/MEM); next state RUN.
  - MULDIV_DONE=1 with DMEM_BUSY=1: set done_latch and keep the DMEM holds.
  - First cycle afterwards with DMEM_BUSY=0 and done_latch=1 is completion; done_latch clears.
  - MULDIV_DONE while the state is RUN, or in the start cycle, is ignored.
- RUN, no DMEM or mul/div activity:
  - BJ_SIG=1: IF_ID_RESET=1, ID_EX_RESET=1, PC_HOLD=0. BJ_SIG overrides LU_HAZ_SIG and IMEM_BUSY.
  - LU_HAZ_SIG=1: PC_HOLD=1, IF_ID_HOLD=1, ID_EX_RESET=1.
  - IMEM_BUSY=1 only: PC_HOLD=1, IF_ID_RESET=1.
  - Nothing asserted: all outputs 0.
- MULDIV_REQ and BJ_SIG together cannot legally occur; if they do, mul/div wins.
- Watchdog:
  - Counts consecutive cycles with state != RUN; clears on RUN.
  - When the count reaches STALL_LIMIT, STALL_TIMEOUT sets and stays set until RESET.
  - Sequencing is unaffected.
- STALL_CYCLES: +1 on every clock edge where PC_HOLD=1; saturates at all-ones (no wrap).
- Reset mid-operation: FSM goes straight to RUN and done_latch clears. A pending mul/div is re-started only when MULDIV_REQ is seen in RUN.

Decomposition:
- Shared header pipeline_ctrl_defs.vh holds:
  - state encodings: RUN=2'b00, DMEM_WAIT=2'b01, MULDIV_WAIT=2'b10;
  - the hold/reset bit-vector index constants.
- One sub-module, stall_watchdog: consecutive-cycle counter with sticky flag, parameterised by STALL_LIMIT.

Test Plan:
- Single-input cases, idle otherwise:
  - All inputs 0 -> all outputs 0, STALL_CYCLES stays 0.
  - BJ_SIG=1 with LU_HAZ_SIG=1 -> IF_ID_RESET=1, ID_EX_RESET=1, IF_ID_HOLD=0, PC_HOLD=0.
  - LU_HAZ_SIG=1 alone -> PC_HOLD=1, IF_ID_HOLD=1, ID_EX_RESET=1.
- Mul/div without memory wait: MULDIV_REQ=1 in RUN, MULDIV_DONE pulsed 5 cycles later:
  - MULDIV_START high exactly 1 cycle.
  - Holds asserted for 5 cycles, then all outputs 0 in the DONE cycle.
  - STALL_CYCLES=5.
- Mul/div completing under a memory wait: MULDIV_WAIT with DMEM_BUSY=1 for 3 cycles and MULDIV_DONE in the 2nd of those cycles:
  - EX_MEM_HOLD=1 and MEM_WB_RESET=1 for 3 cycles.
  - Completion in the 4th cycle; state returns to RUN.
- Watchdog: STALL_LIMIT=8, DMEM_BUSY held 10 cycles -> STALL_TIMEOUT rises after 8 DMEM_WAIT cycles and stays 1 after DMEM_BUSY drops.
- Counter saturation and async reset:
  - STALL_CNT_WIDTH=4 with PC_HOLD held 20 cycles -> STALL_CYCLES=4'hF.
  - RESET pulsed asynchronously mid-MULDIV_WAIT -> all outputs 0 immediately, state RUN, counters 0.
